// File: rtl/alu_16.sv
// 16-bit 74181/74182-style ALU: four 4-bit slices joined by a lookahead carry unit.
// One cycle of latency to all outputs; no flow control, a new operation is accepted every cycle.

// One 4-bit 74181-equivalent slice with active-high data and active-low group P/G.
module alu181_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [3:0] s_i,
    input  logic       m_i,
    input  logic       cn_i,
    output logic [3:0] f_o,
    output logic       pb_o,
    output logic       gb_o
);

    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] h;
    logic [3:0] c;

    // y is always a subset of x, so y acts as generate and x as propagate
    always_comb begin
        x    = a_i | ({4{s_i[0]}} & b_i) | ({4{s_i[1]}} & ~b_i);
        y    = ({4{s_i[2]}} & a_i & ~b_i) | ({4{s_i[3]}} & a_i & b_i);
        h    = x & ~y;
        c[0] = cn_i;
        c[1] = y[0] | (x[0] & cn_i);
        c[2] = y[1] | (x[1] & y[0]) | (x[1] & x[0] & cn_i);
        c[3] = y[2] | (x[2] & y[1]) | (x[2] & x[1] & y[0]) | (x[2] & x[1] & x[0] & cn_i);
        // logic mode forces every carry high, which turns the sum into ~(x ^ y)
        f_o  = h ^ (c | {4{m_i}});
        pb_o = ~(&x);
        gb_o = ~(y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]));
    end

endmodule

// 74182-equivalent lookahead: active-high carry-in, active-low slice and group P/G.
module cla182 (
    input  logic       cn_i,
    input  logic [3:0] pb_i,
    input  logic [3:0] gb_i,
    output logic       cnx_o,
    output logic       cny_o,
    output logic       cnz_o,
    output logic       pb_o,
    output logic       gb_o
);

    logic [3:0] p;
    logic [3:0] g;

    always_comb begin
        p     = ~pb_i;
        g     = ~gb_i;
        cnx_o = g[0] | (p[0] & cn_i);
        cny_o = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cn_i);
        cnz_o = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cn_i);
        pb_o  = ~(&p);
        gb_o  = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    end

endmodule

module alu_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  S,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        M,
    input  logic        CNb,
    output logic [15:0] F,
    output logic        PBo,
    output logic        GBo,
    output logic        CN16b,
    output logic        AEBo
);

    logic        cin;
    logic [3:0]  slice_cn;
    logic [3:0]  slice_pb;
    logic [3:0]  slice_gb;
    logic [15:0] f_w;
    logic        cnx;
    logic        cny;
    logic        cnz;
    logic        grp_pb;
    logic        grp_gb;
    logic        cout;

    logic [15:0] f_d,     f_q;
    logic        pbo_d,   pbo_q;
    logic        gbo_d,   gbo_q;
    logic        cn16b_d, cn16b_q;
    logic        aeb_d,   aeb_q;

    assign cin      = ~CNb;
    assign slice_cn = {cnz, cny, cnx, cin};

    for (genvar i = 0; i < 4; i++) begin : g_slice
        alu181_slice u_slice (
            .a_i  (A[4*i +: 4]),
            .b_i  (B[4*i +: 4]),
            .s_i  (S),
            .m_i  (M),
            .cn_i (slice_cn[i]),
            .f_o  (f_w[4*i +: 4]),
            .pb_o (slice_pb[i]),
            .gb_o (slice_gb[i])
        );
    end

    cla182 u_cla (
        .cn_i  (cin),
        .pb_i  (slice_pb),
        .gb_i  (slice_gb),
        .cnx_o (cnx),
        .cny_o (cny),
        .cnz_o (cnz),
        .pb_o  (grp_pb),
        .gb_o  (grp_gb)
    );

    // carry out of bit 15 rebuilt from the group terms
    assign cout = ~grp_gb | (~grp_pb & cin);

    always_comb begin
        f_d     = f_w;
        pbo_d   = grp_pb;
        gbo_d   = grp_gb;
        cn16b_d = M ? 1'b1 : ~cout;
        aeb_d   = &f_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q     <= 16'h0000;
            pbo_q   <= 1'b1;
            gbo_q   <= 1'b1;
            cn16b_q <= 1'b1;
            aeb_q   <= 1'b0;
        end else begin
            f_q     <= f_d;
            pbo_q   <= pbo_d;
            gbo_q   <= gbo_d;
            cn16b_q <= cn16b_d;
            aeb_q   <= aeb_d;
        end
    end

    assign F     = f_q;
    assign PBo   = pbo_q;
    assign GBo   = gbo_q;
    assign CN16b = cn16b_q;
    assign AEBo  = aeb_q;

endmodule

// File: tb/tb_alu_16.sv
// Directed and random bench for alu_16 with a queue-based scoreboard.
`timescale 1ns/1ps

module tb_alu_16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  S;
    logic [15:0] A;
    logic [15:0] B;
    logic        M;
    logic        CNb;
    logic [15:0] F;
    logic        PBo;
    logic        GBo;
    logic        CN16b;
    logic        AEBo;

    typedef struct packed {
        logic [15:0] f;
        logic        pbo;
        logic        gbo;
        logic        cn16b;
        logic        aeb;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    alu_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .S     (S),
        .A     (A),
        .B     (B),
        .M     (M),
        .CNb   (CNb),
        .F     (F),
        .PBo   (PBo),
        .GBo   (GBo),
        .CN16b (CN16b),
        .AEBo  (AEBo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                                   input logic m, input logic cnb);
        exp_t        e;
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] sum;
        logic [16:0] xy;
        logic [15:0] lf;
        x   = a | ({16{s[0]}} & b) | ({16{s[1]}} & ~b);
        y   = ({16{s[2]}} & a & ~b) | ({16{s[3]}} & a & b);
        sum = {1'b0, x} + {1'b0, y} + {16'b0, ~cnb};
        xy  = {1'b0, x} + {1'b0, y};
        case (s)
            4'd0:    lf = ~a;
            4'd1:    lf = ~(a | b);
            4'd2:    lf = ~a & b;
            4'd3:    lf = 16'h0000;
            4'd4:    lf = ~(a & b);
            4'd5:    lf = ~b;
            4'd6:    lf = a ^ b;
            4'd7:    lf = a & ~b;
            4'd8:    lf = ~a | b;
            4'd9:    lf = ~(a ^ b);
            4'd10:   lf = b;
            4'd11:   lf = a & b;
            4'd12:   lf = 16'hFFFF;
            4'd13:   lf = a | ~b;
            4'd14:   lf = a | b;
            default: lf = a;
        endcase
        e.f     = m ? lf : sum[15:0];
        e.cn16b = m ? 1'b1 : ~sum[16];
        e.pbo   = ~(&x);
        e.gbo   = ~xy[16];
        e.aeb   = &e.f;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".F"},     F,     16'h0000);
        chk({tag, ".PBo"},   PBo,   1'b1);
        chk({tag, ".GBo"},   GBo,   1'b1);
        chk({tag, ".CN16b"}, CN16b, 1'b1);
        chk({tag, ".AEBo"},  AEBo,  1'b0);
    endtask

    task automatic step(input string tag, input logic [3:0] s, input logic [15:0] a,
                        input logic [15:0] b, input logic m, input logic cnb);
        exp_t e;
        @(negedge clk);
        S = s; A = a; B = b; M = m; CNb = cnb;
        sb_q.push_back(model(s, a, b, m, cnb));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".F"},     F,     e.f);
        chk({tag, ".PBo"},   PBo,   e.pbo);
        chk({tag, ".GBo"},   GBo,   e.gbo);
        chk({tag, ".CN16b"}, CN16b, e.cn16b);
        chk({tag, ".AEBo"},  AEBo,  e.aeb);
    endtask

    initial begin
        rst_n = 1'b1;
        S = 4'hA; A = 16'h1234; B = 16'h5678; M = 1'b0; CNb = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_reset("reset_async");
        @(negedge clk);
        rst_n = 1'b1;

        step("logic_xor", 4'b0110, 16'h3AB9, 16'h1232, 1'b1, 1'b1);
        chk("logic_xor.lit", F, 16'h288B);
        chk("logic_xor.cn", CN16b, 1'b1);
        step("logic_and", 4'b1011, 16'h3AB9, 16'h1232, 1'b1, 1'b0);
        chk("logic_and.lit", F, 16'h1230);
        chk("logic_and.cn", CN16b, 1'b1);

        step("sub", 4'b0110, 16'd12345, 16'd11938, 1'b0, 1'b1);
        chk("sub.lit", F, 16'd406);
        chk("sub.cn", CN16b, 1'b0);
        step("sub_cin", 4'b0110, 16'd12345, 16'd11938, 1'b0, 1'b0);
        chk("sub_cin.lit", F, 16'd407);
        chk("sub_cin.cn", CN16b, 1'b0);

        step("add_wrap", 4'b1001, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        chk("add_wrap.lit", F, 16'h0000);
        chk("add_wrap.cn", CN16b, 1'b0);
        chk("add_wrap.gbo", GBo, 1'b0);
        chk("add_wrap.aeb", AEBo, 1'b0);

        step("cmp_eq", 4'b0110, 16'h0005, 16'h0005, 1'b0, 1'b1);
        chk("cmp_eq.lit", F, 16'hFFFF);
        chk("cmp_eq.aeb", AEBo, 1'b1);
        chk("cmp_eq.pbo", PBo, 1'b0);
        chk("cmp_eq.cn", CN16b, 1'b1);

        step("const_ones", 4'b1100, 16'h1357, 16'h2468, 1'b1, 1'b1);
        chk("const_ones.lit", F, 16'hFFFF);
        chk("const_ones.aeb", AEBo, 1'b1);
        step("const_zero", 4'b0011, 16'h1357, 16'h2468, 1'b1, 1'b0);
        chk("const_zero.lit", F, 16'h0000);
        chk("const_zero.aeb", AEBo, 1'b0);

        // inputs changed between edges must not reach the outputs
        step("hold_base", 4'b1001, 16'h0003, 16'h0004, 1'b0, 1'b1);
        A = 16'h0100; B = 16'h0200; S = 4'b0000;
        #2 chk("hold.F", F, 16'h0007);

        for (int i = 0; i < 32; i++)
            step($sformatf("sweep_s%0d_m%0d", i % 16, i / 16), 4'(i % 16), 16'hC3A5, 16'h5A3C,
                 1'(i / 16), 1'(i % 3 == 0));

        for (int i = 0; i < 40; i++)
            step($sformatf("rand%0d", i), 4'($urandom_range(15)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(1)), 1'($urandom_range(1)));

        // reset mid-stream drops the operation that was about to be registered
        step("pre_reset", 4'b1001, 16'h8000, 16'h8000, 1'b0, 1'b0);
        @(negedge clk);
        S = 4'b1001; A = 16'h0001; B = 16'h0001; M = 1'b0; CNb = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_mid");
        @(posedge clk);
        #1 chk_reset("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 4'b1001, 16'h0001, 16'h0001, 1'b0, 1'b1);
        chk("post_reset.lit", F, 16'h0002);

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_16.md
ALU_16 -- requirements
Module: alu_16

Interface
REQ-001 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 Port S, input, 4 bits: function select.
REQ-004 Port A, input, 16 bits: operand A, active-high data.
REQ-005 Port B, input, 16 bits: operand B, active-high data.
REQ-006 Port M, input, 1 bit: mode; 1 = logic, 0 = arithmetic.
REQ-007 Port CNb, input, 1 bit: carry-in, active-low (0 = carry in).
REQ-008 Port F, output, 16 bits: result, registered.
REQ-009 Port PBo, output, 1 bit: group propagate, active-low, registered.
REQ-010 Port GBo, output, 1 bit: group generate, active-low, registered.
REQ-011 Port CN16b, output, 1 bit: carry-out, active-low, registered.
REQ-012 Port AEBo, output, 1 bit: A=B flag, registered; 1 when F is all ones.

Function
REQ-013 The datapath SHALL be four 4-bit 74181-equivalent slices joined by a 74182-equivalent carry-lookahead unit.
REQ-014 The datapath SHALL be combinational; all outputs SHALL be registered on clk with one cycle of latency.
REQ-015 Per bit, X = A | (S0&B) | (S1&~B) and Y = (S2&A&~B) | (S3&A&B).
REQ-016 Arithmetic mode (M=0): F = (X + Y + ~CNb) mod 2^16.
REQ-016a This yields, per S 0..15: A, A|B, A|~B, -1, A+(A&~B), (A|B)+(A&~B), A-B-1, (A&~B)-1, A+(A&B), A+B, (A|~B)+(A&B), (A&B)-1, A+A, (A|B)+A, (A|~B)+A, A-1.
REQ-016b Each arithmetic result gains +1 when CNb=0.
REQ-017 Logic mode (M=1): F is bitwise; per S 0..15: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A; CNb is ignored.
REQ-018 CN16b SHALL be the inverse of bit 16 of X+Y+~CNb when M=0, and SHALL be 1 when M=1.
REQ-019 PBo SHALL be 0 exactly when all 16 bits of X are 1; GBo SHALL be 0 exactly when X+Y (carry-in 0) carries out of bit 15.
REQ-019a PBo and GBo SHALL be computed in both modes.
REQ-020 AEBo SHALL be the AND of all 16 bits of the F value being registered; with M=0, S=0110, CNb=1 it flags A=B.
REQ-021 Inputs changing between edges SHALL have no effect until the next rising edge; no other internal state exists.

Reset
REQ-022 While rst_n=0, outputs SHALL be forced immediately, without waiting for clk, to F=0x0000, PBo=1, GBo=1, CN16b=1, AEBo=0.
REQ-023 On rst_n release, the first rising edge SHALL register the current inputs normally.
REQ-024 Reset asserted mid-stream SHALL discard the pending result.

Verification
REQ-025 Reset: rst_n=0 with arbitrary inputs -> F=0, PBo=1, GBo=1, CN16b=1, AEBo=0 before any clk edge.
REQ-026 Logic mode: M=1, A=0x3AB9, B=0x1232; S=0110 -> F=0x288B next cycle; S=1011 -> F=0x1230; CN16b=1 in both cases.
REQ-027 Subtract: M=0, CNb=1, S=0110, A=12345, B=11938 -> F=406, CN16b=0; same with CNb=0 -> F=407, CN16b=0.
REQ-028 Add wrap: M=0, CNb=1, S=1001, A=0xFFFF, B=0x0001 -> F=0x0000, CN16b=0, GBo=0, AEBo=0.
REQ-029 Compare: M=0, CNb=1, S=0110, A=B=0x0005 -> F=0xFFFF, AEBo=1, PBo=0, CN16b=1.
REQ-030 Constants: M=1, S=1100 -> F=0xFFFF, AEBo=1; M=1, S=0011 -> F=0x0000, AEBo=0.
